// File: rtl/spmv_stream_pkg.sv
// Shared sizing helpers and the word-slot record used by the stream width converters.
// The slot record is sized for the widest supported word; users keep only the low bits.
package spmv_stream_pkg;

  localparam int MAX_WORD_W  = 1024;
  localparam int MAX_COUNT_W = 8;

  typedef struct packed {
    logic [MAX_WORD_W-1:0]  data;
    logic [MAX_COUNT_W-1:0] count;
    logic                   last;
  } slot_t;

  function automatic int calcRatio(input int slaveW, input int masterW);
    return slaveW / masterW;
  endfunction

  function automatic int calcCountW(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/stream_word_slot.sv
// One buffered word slot: a full flag plus the registered word record.
// Load wins over clear so a slot can be refilled in the same cycle it is freed.
module stream_word_slot
  import spmv_stream_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  clear_i,
  input  slot_t slot_i,
  output logic  full_o,
  output slot_t slot_o
);

  slot_t slot_q, slot_d;
  logic  full_q, full_d;

  // Clearing also drops the stored last flag so an empty slot never advertises an end of packet.
  always_comb begin
    slot_d = slot_q;
    full_d = full_q;
    if (load_i) begin
      slot_d = slot_i;
      full_d = 1'b1;
    end else if (clear_i) begin
      slot_d.last = 1'b0;
      full_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      full_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      full_q <= full_d;
    end
  end

  assign full_o = full_q;
  assign slot_o = slot_q;

endmodule

// File: rtl/stream_downsizer.sv
// Splits wide input words into MASTER_WIDTH slices, slice 0 first, with a two-word buffer
// (active + pending) so a full-rate stream never stalls between words.
module stream_downsizer
  import spmv_stream_pkg::*;
#(
  parameter int  SLAVE_WIDTH  = 256,
  parameter int  MASTER_WIDTH = 64,
  localparam int RATIO        = calcRatio(SLAVE_WIDTH, MASTER_WIDTH),
  localparam int CNT_W        = calcCountW(RATIO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SLAVE_WIDTH-1:0]  s_data,
  input  logic [CNT_W-1:0]        s_count,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [MASTER_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy
);

  if (SLAVE_WIDTH % MASTER_WIDTH != 0 || RATIO < 2 ||
      SLAVE_WIDTH > MAX_WORD_W || CNT_W > MAX_COUNT_W) begin : gBadParams
    $error("stream_downsizer: SLAVE_WIDTH must be an integer multiple (>= 2) of MASTER_WIDTH");
  end

  slot_t                   activeSlot, pendingSlot, inSlot, activeNext;
  logic                    activeFull, pendingFull;
  logic [SLAVE_WIDTH-1:0]  activeData;
  logic [CNT_W-1:0]        activeCount, countNorm, idx_q, idx_d;
  logic                    inFire, outFire, lastSlice, activeFree, activeOpen;
  logic                    loadActive, clearActive, loadPending, clearPending;
  logic                    unusedBits;

  assign activeData  = activeSlot.data[SLAVE_WIDTH-1:0];
  assign activeCount = activeSlot.count[CNT_W-1:0];
  assign unusedBits  = ^activeSlot;

  // Handshake outputs depend on registered state only, never on s_valid or m_ready.
  assign s_ready = ~rst & ~pendingFull;
  assign m_valid = activeFull;
  assign busy    = activeFull | pendingFull;

  assign inFire     = s_valid & s_ready;
  assign outFire    = activeFull & m_ready;
  assign lastSlice  = (idx_q == activeCount - CNT_W'(1));
  assign activeFree = outFire & lastSlice;
  assign activeOpen = ~activeFull | (activeFree & ~pendingFull);

  assign loadActive   = (inFire & activeOpen) | (activeFree & pendingFull);
  assign clearActive  = activeFree;
  assign loadPending  = inFire & ~activeOpen;
  assign clearPending = activeFree & pendingFull;

  assign m_data = activeData[int'(idx_q)*MASTER_WIDTH +: MASTER_WIDTH];
  assign m_last = activeSlot.last & lastSlice;

  // Out-of-range counts (zero or above RATIO) mean a fully populated word.
  always_comb begin
    countNorm = s_count;
    if (s_count == '0 || s_count > CNT_W'(RATIO)) begin
      countNorm = CNT_W'(RATIO);
    end
  end

  always_comb begin
    inSlot                       = '0;
    inSlot.data[SLAVE_WIDTH-1:0] = s_data;
    inSlot.count[CNT_W-1:0]      = countNorm;
    inSlot.last                  = s_last;
    activeNext = (activeFree & pendingFull) ? pendingSlot : inSlot;
  end

  always_comb begin
    idx_d = idx_q;
    if (activeFree) begin
      idx_d = '0;
    end else if (outFire) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  stream_word_slot uActive (
    .clk     (clk),
    .rst     (rst),
    .load_i  (loadActive),
    .clear_i (clearActive),
    .slot_i  (activeNext),
    .full_o  (activeFull),
    .slot_o  (activeSlot)
  );

  stream_word_slot uPending (
    .clk     (clk),
    .rst     (rst),
    .load_i  (loadPending),
    .clear_i (clearPending),
    .slot_i  (inSlot),
    .full_o  (pendingFull),
    .slot_o  (pendingSlot)
  );

endmodule
